// File: rtl/emitter.sv
// Streams completed stitched-buffer quarters to the codec, zero-clearing each sample after it is read.
// Latency: go_in to first READY is 3 cycles; sample_req to sample_valid is 1 cycle. Early requests are answered with 0 and underrun.
module emitter #(
    parameter int QUARTER_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go_in,
    input  logic [1:0]  window_start,
    output logic [11:0] buf_addr,
    input  logic [15:0] buf_data,
    output logic [15:0] buf_wdata,
    output logic        buf_wren,
    input  logic        sample_req,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic        quarter_done,
    output logic        underrun,
    output logic        overrun
);

    localparam int IDX_W = $clog2(QUARTER_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(QUARTER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_DATA,
        READY
    } state_t;

    state_t           state;
    logic [1:0]       cur_q;
    logic [IDX_W-1:0] idx;
    logic [1:0]       pend_q;
    logic             pend_v;
    logic [15:0]      hold;

    logic serve;
    logic wrap;
    logic can_start;
    logic start_pend;
    logic start_go;

    // A quarter can begin from IDLE or directly off the last sample of the previous one.
    always_comb begin
        serve      = (state == READY) && sample_req;
        wrap       = serve && (idx == LAST_IDX);
        can_start  = (state == IDLE) || wrap;
        start_pend = can_start && pend_v;
        start_go   = can_start && !pend_v && go_in;
    end

    assign buf_addr  = {cur_q, idx};
    assign buf_wdata = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cur_q        <= '0;
            idx          <= '0;
            pend_q       <= '0;
            pend_v       <= 1'b0;
            hold         <= '0;
            buf_wren     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            quarter_done <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= sample_req;
            underrun     <= sample_req && (state != READY);
            quarter_done <= wrap;
            buf_wren     <= (state == FETCH_ADDR);
            if (sample_req) begin
                sample_data <= serve ? hold : '0;
            end

            case (state)
                FETCH_ADDR: state <= FETCH_DATA;
                FETCH_DATA: begin
                    hold  <= buf_data;
                    state <= READY;
                end
                READY: begin
                    if (serve && !wrap) begin
                        idx   <= idx + 1'b1;
                        state <= FETCH_ADDR;
                    end
                end
                default: ;
            endcase

            if (start_pend) begin
                cur_q <= pend_q;
                idx   <= '0;
                state <= FETCH_ADDR;
            end else if (start_go) begin
                cur_q <= window_start;
                idx   <= '0;
                state <= FETCH_ADDR;
            end else if (wrap) begin
                state <= IDLE;
            end

            // The pending slot may refill in the same cycle it is consumed.
            if (go_in && !start_go) begin
                if (!pend_v || start_pend) begin
                    pend_q <= window_start;
                    pend_v <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (start_pend) begin
                pend_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_emitter.sv
// Directed bench for emitter with a synchronous-read model of the stitched buffer.
module tb_emitter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go_in = 1'b0;
    logic [1:0]  window_start = 2'd0;
    logic [11:0] buf_addr;
    logic [15:0] buf_data;
    logic [15:0] buf_wdata;
    logic        buf_wren;
    logic        sample_req = 1'b0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        quarter_done;
    logic        underrun;
    logic        overrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    emitter #(.QUARTER_LEN(1024)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .go_in        (go_in),
        .window_start (window_start),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .buf_wdata    (buf_wdata),
        .buf_wren     (buf_wren),
        .sample_req   (sample_req),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .quarter_done (quarter_done),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    logic [15:0] mem [0:4095];
    logic        fill = 1'b0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
        end else if (buf_wren) begin
            mem[buf_addr] <= buf_wdata;
        end
        buf_data <= mem[buf_addr];
    end

    int          wren_cnt = 0;
    int          qd_cnt = 0;
    int          rw_err = 0;
    int          pulse_err = 0;
    logic [11:0] prev_addr = '0;
    logic        prev_wren = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_q = 1'b0;
    logic        prev_u = 1'b0;

    // A clear-write must follow a non-writing cycle that presented the same address.
    always @(negedge clk) begin
        if (buf_wren) begin
            wren_cnt++;
            if (prev_wren || prev_addr !== buf_addr) rw_err++;
        end
        if (quarter_done) qd_cnt++;
        if ((sample_valid && prev_v) || (quarter_done && prev_q) || (underrun && prev_u)) pulse_err++;
        prev_addr = buf_addr;
        prev_wren = buf_wren;
        prev_v    = sample_valid;
        prev_q    = quarter_done;
        prev_u    = underrun;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reload();
        fill = 1'b1;
        step();
        fill = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (buf_addr !== 12'd0 || buf_wren !== 1'b0 || buf_wdata !== 16'd0) begin
            $display("FAIL reset_buf addr=%0d wren=%0b wdata=%0h want 0/0/0", buf_addr, buf_wren, buf_wdata);
        end else passed++;
        checks++;
        if (sample_data !== 16'd0 || sample_valid !== 1'b0) begin
            $display("FAIL reset_sample data=%0h valid=%0b want 0/0", sample_data, sample_valid);
        end else passed++;
        checks++;
        if (quarter_done !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL reset_flags qd=%0b ur=%0b ov=%0b want 0/0/0", quarter_done, underrun, overrun);
        end else passed++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_idle_underrun();
        int w0;
        w0 = wren_cnt;
        for (int k = 0; k < 3; k++) begin
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            checks++;
            if (sample_valid !== 1'b1 || underrun !== 1'b1 || sample_data !== 16'd0) begin
                $display("FAIL idle_req%0d valid=%0b ur=%0b data=%0h want 1/1/0", k, sample_valid, underrun, sample_data);
            end else passed++;
            repeat (3) step();
        end
        checks++;
        if (wren_cnt - w0 !== 0) $display("FAIL idle_wren writes=%0d want 0", wren_cnt - w0);
        else passed++;
    endtask

    task automatic test_playback();
        int w0, q0, bad, zbad;
        logic [15:0] exp_d, first;
        reload();
        w0 = wren_cnt;
        q0 = qd_cnt;
        go_in = 1'b1;
        window_start = 2'd2;
        step();
        go_in = 1'b0;
        checks++;
        if (buf_addr !== 12'd2048 || buf_wren !== 1'b0) begin
            $display("FAIL play_fetch addr=%0d wren=%0b want 2048/0", buf_addr, buf_wren);
        end else passed++;
        step();
        checks++;
        if (buf_addr !== 12'd2048 || buf_wren !== 1'b1) begin
            $display("FAIL play_clear addr=%0d wren=%0b want 2048/1", buf_addr, buf_wren);
        end else passed++;
        step();
        bad = 0;
        first = '0;
        for (int i = 0; i < 1024; i++) begin
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            exp_d = 16'(2048 + i);
            if (i == 0) first = sample_data;
            if (sample_valid !== 1'b1 || sample_data !== exp_d || underrun !== 1'b0 ||
                quarter_done !== (i == 1023)) bad++;
            repeat (7) step();
        end
        checks++;
        if (first !== 16'd2048) $display("FAIL play_first got %0d want 2048", first);
        else passed++;
        checks++;
        if (sample_data !== 16'd3071) $display("FAIL play_last got %0d want 3071", sample_data);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL play_stream bad_samples=%0d want 0", bad);
        else passed++;
        checks++;
        if (qd_cnt - q0 !== 1) $display("FAIL play_qd pulses=%0d want 1", qd_cnt - q0);
        else passed++;
        zbad = 0;
        for (int a = 2048; a < 3072; a++) if (mem[a] !== 16'd0) zbad++;
        checks++;
        if (zbad !== 0) $display("FAIL play_cleared nonzero=%0d want 0", zbad);
        else passed++;
        checks++;
        if (mem[2047] !== 16'd2047 || mem[3072] !== 16'd3072) begin
            $display("FAIL play_neighbours m2047=%0d m3072=%0d want 2047/3072", mem[2047], mem[3072]);
        end else passed++;
        checks++;
        if (wren_cnt - w0 !== 1024) $display("FAIL play_writes got %0d want 1024", wren_cnt - w0);
        else passed++;
    endtask

    task automatic test_go_on_last();
        int bad0, bad3;
        logic [15:0] exp_d;
        reload();
        go_in = 1'b1;
        window_start = 2'd0;
        step();
        go_in = 1'b0;
        repeat (2) step();
        bad0 = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) begin
                go_in = 1'b1;
                window_start = 2'd3;
            end
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            go_in = 1'b0;
            exp_d = 16'(i);
            if (sample_valid !== 1'b1 || sample_data !== exp_d || underrun !== 1'b0) bad0++;
            if (i == 1023) begin
                checks++;
                if (quarter_done !== 1'b1 || buf_addr !== 12'd3072 || buf_wren !== 1'b0) begin
                    $display("FAIL last_go_start qd=%0b addr=%0d wren=%0b want 1/3072/0", quarter_done, buf_addr, buf_wren);
                end else passed++;
            end
            repeat (3) step();
        end
        bad3 = 0;
        for (int i = 0; i < 1024; i++) begin
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            exp_d = 16'(3072 + i);
            if (sample_valid !== 1'b1 || sample_data !== exp_d || underrun !== 1'b0 ||
                quarter_done !== (i == 1023)) bad3++;
            repeat (3) step();
        end
        checks++;
        if (bad0 !== 0 || bad3 !== 0) $display("FAIL last_go_stream bad_q0=%0d bad_q3=%0d want 0/0", bad0, bad3);
        else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL last_go_overrun got %0b want 0", overrun);
        else passed++;
    endtask

    task automatic test_overrun();
        int bad0, bad1;
        logic ov_after;
        logic [15:0] exp_d;
        reload();
        go_in = 1'b1;
        window_start = 2'd0;
        step();
        go_in = 1'b0;
        repeat (2) step();
        bad0 = 0;
        ov_after = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            exp_d = 16'(i);
            if (sample_valid !== 1'b1 || sample_data !== exp_d || underrun !== 1'b0) bad0++;
            for (int g = 0; g < 3; g++) begin
                if (g == 0 && i == 5) begin
                    go_in = 1'b1;
                    window_start = 2'd1;
                end
                if (g == 0 && i == 10) begin
                    go_in = 1'b1;
                    window_start = 2'd3;
                end
                step();
                go_in = 1'b0;
                if (g == 0 && i == 10) ov_after = overrun;
            end
        end
        checks++;
        if (ov_after !== 1'b1) $display("FAIL ovr_set got %0b want 1", ov_after);
        else passed++;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (quarter_done !== 1'b1 || sample_data !== 16'd1023 || buf_addr !== 12'd1024 || buf_wren !== 1'b0) begin
            $display("FAIL ovr_chain qd=%0b data=%0d addr=%0d wren=%0b want 1/1023/1024/0",
                     quarter_done, sample_data, buf_addr, buf_wren);
        end else passed++;
        step();
        checks++;
        if (buf_wren !== 1'b1 || buf_addr !== 12'd1024) begin
            $display("FAIL ovr_chain_clear wren=%0b addr=%0d want 1/1024", buf_wren, buf_addr);
        end else passed++;
        step();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (sample_valid !== 1'b1 || underrun !== 1'b0 || sample_data !== 16'd1024) begin
            $display("FAIL ovr_q1_first valid=%0b ur=%0b data=%0d want 1/0/1024", sample_valid, underrun, sample_data);
        end else passed++;
        bad1 = 0;
        for (int i = 1; i < 1024; i++) begin
            repeat (3) step();
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            exp_d = 16'(1024 + i);
            if (sample_valid !== 1'b1 || sample_data !== exp_d || underrun !== 1'b0 ||
                quarter_done !== (i == 1023)) bad1++;
        end
        checks++;
        if (bad0 !== 0 || bad1 !== 0) $display("FAIL ovr_stream bad_q0=%0d bad_q1=%0d want 0/0", bad0, bad1);
        else passed++;
        repeat (4) step();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (underrun !== 1'b1 || sample_data !== 16'd0 || overrun !== 1'b1) begin
            $display("FAIL ovr_dropped ur=%0b data=%0d ov=%0b want 1/0/1", underrun, sample_data, overrun);
        end else passed++;
        repeat (3) step();
    endtask

    task automatic test_early_req_and_reset();
        reload();
        go_in = 1'b1;
        window_start = 2'd1;
        step();
        go_in = 1'b0;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (sample_valid !== 1'b1 || underrun !== 1'b1 || sample_data !== 16'd0) begin
            $display("FAIL early_req valid=%0b ur=%0b data=%0d want 1/1/0", sample_valid, underrun, sample_data);
        end else passed++;
        repeat (7) step();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (sample_valid !== 1'b1 || underrun !== 1'b0 || sample_data !== 16'd1024) begin
            $display("FAIL early_next valid=%0b ur=%0b data=%0d want 1/0/1024", sample_valid, underrun, sample_data);
        end else passed++;
        repeat (3) step();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (buf_addr !== 12'd0 || buf_wren !== 1'b0 || sample_data !== 16'd0 || sample_valid !== 1'b0 ||
            quarter_done !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL async_reset addr=%0d wren=%0b data=%0d valid=%0b qd=%0b ur=%0b ov=%0b want all 0",
                     buf_addr, buf_wren, sample_data, sample_valid, quarter_done, underrun, overrun);
        end else passed++;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        step();
        checks++;
        if (mem[1025] !== 16'd0 || mem[1026] !== 16'd1026) begin
            $display("FAIL abort_mem m1025=%0d m1026=%0d want 0/1026", mem[1025], mem[1026]);
        end else passed++;
        go_in = 1'b1;
        window_start = 2'd3;
        step();
        go_in = 1'b0;
        checks++;
        if (buf_addr !== 12'd3072) $display("FAIL restart_addr got %0d want 3072", buf_addr);
        else passed++;
        repeat (2) step();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        checks++;
        if (sample_valid !== 1'b1 || underrun !== 1'b0 || sample_data !== 16'd3072) begin
            $display("FAIL restart_first valid=%0b ur=%0b data=%0d want 1/0/3072", sample_valid, underrun, sample_data);
        end else passed++;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_playback();
        test_go_on_last();
        test_overrun();
        test_early_req_and_reset();
        checks++;
        if (rw_err !== 0) $display("FAIL read_clear_order errors=%0d want 0", rw_err);
        else passed++;
        checks++;
        if (pulse_err !== 0) $display("FAIL pulse_width errors=%0d want 0", pulse_err);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
